lif_neuron_array: RTL and testbench
===================================

Name: lif_neuron_array

Overview:
Time-multiplexed array of N binary-input LIF neurons that share one leak/integrate/fire datapath. Per-neuron state lives in internal register arrays: potential and refractory counter. On each accepted timestep it sweeps neurons 0..N-1, one per cycle, and returns a spike vector plus a spike count. Successor to the single-neuron LIF. It adds channel count, a programmable synaptic weight, a refractory period, saturating accumulation and a valid/ready step handshake.

Parameters:
N_NEURONS, 8, number of neurons; must be ≥1.
POTENTIAL_WIDTH, 16, width of each unsigned potential, in fixed-point units.
FRACTION_BITS, 8, fractional bits; 1.0 = 2^FRACTION_BITS.
REFRAC_WIDTH, 4, width of the refractory period and of each counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high; clears all state.
in_valid  in  1  a timestep request is present.
in_ready  out  1  block is able to accept a timestep (high only in IDLE).
in_spikes  in  N_NEURONS  binary input per neuron for this timestep.
lambda_val_scaled  in  FRACTION_BITS  leak factor × 2^FRACTION_BITS.
weight_scaled  in  POTENTIAL_WIDTH  amount added when an input bit is 1.
theta_val_scaled  in  POTENTIAL_WIDTH  firing threshold.
reset_val_scaled  in  POTENTIAL_WIDTH  potential loaded after a spike.
refrac_steps  in  REFRAC_WIDTH  number of timesteps a neuron is inhibited after it spikes.
out_valid  out  1  one-cycle pulse; out_spikes and spike_count are valid.
out_spikes  out  N_NEURONS  spike vector for the completed timestep.
spike_count  out  $clog2(N_NEURONS+1)  population count of out_spikes.

Behaviour:
- Reset (asynchronous): all potentials = 0, all refractory counters = 0, FSM = IDLE, in_ready = 1, out_valid = 0, out_spikes = 0, spike_count = 0.
- FSM states and transitions:
  - IDLE: on in_valid && in_ready, latch in_spikes, lambda, weight, theta, reset_val and refrac_steps; set idx = 0; go to UPDATE. Input changes after acceptance have no effect on the current step.
  - UPDATE: process neuron idx this cycle. If idx == N_NEURONS-1, go to DONE; otherwise idx++.
  - DONE: out_valid = 1 for exactly this cycle; out_spikes and spike_count are registered and hold their values until the next DONE; return to IDLE.
- Timing:
  - Latency is fixed: acceptance at edge k gives out_valid high during cycle k+N_NEURONS+1.
  - Throughput is one step per N_NEURONS+2 cycles.
  - There is no output backpressure.
- Per-neuron update, when its refractory counter r > 0:
  - r <= r-1.
  - Potential is unchanged.
  - Spike bit = 0.
  - The input bit is ignored.
- Per-neuron update, when r == 0:
  - leak = (P × lambda) >> FRACTION_BITS. Full-width product, truncating (floor). The result always fits in POTENTIAL_WIDTH.
  - sum = leak + (in_bit ? weight : 0). Compute at POTENTIAL_WIDTH+1 bits and saturate to 2^POTENTIAL_WIDTH−1 on overflow.
  - If sum ≥ theta (unsigned): spike bit = 1, P <= reset_val, r <= refrac_steps.
  - Otherwise: spike bit = 0, P <= sum.
- Boundary conditions:
  - refrac_steps = 0: no inhibition; the neuron may spike on consecutive steps.
  - theta = 0: every non-refractory neuron spikes every step.
  - lambda = 0: potential is fully cleared each step before the weight is added.
  - Maximum lambda is (2^FB−1)/2^FB; lambda can never reach 1.0, so the potential always leaks.
  - reset_val may be ≥ theta. The neuron still does not fire on the spike step itself; it fires on its next non-refractory step.
  - reset asserted mid-UPDATE: the partial step is discarded immediately and no out_valid is produced.
  - in_valid while busy: ignored (in_ready = 0); the requester must hold in_valid.

Test Plan:
1. Reset, then idle. Require: in_ready = 1, out_valid = 0, spike_count = 0.
2. Basic integrate and fire. Setup: N=4, PW=16, FB=8, lambda=128, weight=256, theta=384, reset_val=0, refrac_steps=0, in_spikes=4'b0001 every step. Require:
   - Step 1: out_spikes = 0 (P0 = 256).
   - Step 2: out_spikes = 4'b0001, spike_count = 1 (sum = 384 ≥ theta, P0 = 0).
   - Step 3: no spike.
   - Step 4: spike. The pattern then repeats with period 2.
   - out_valid exactly N+1 cycles after each acceptance.
3. Refractory period. Same as test 2 with refrac_steps=2. Require:
   - Spike at step 2.
   - Steps 3 and 4: no spike, P0 held at 0.
   - Step 5: P0 = 256, no spike.
   - Step 6: spike.
4. Saturation. lambda=255, weight=0xF000, theta=0xFFFF, input 1. Require:
   - Step 1: P = 0xF000, no spike.
   - Step 2: leak = 0xEF10; the sum saturates to 0xFFFF, so the neuron spikes.
5. Channel independence and popcount. N=4, in_spikes=4'b1111, theta=256, weight=256. Require out_spikes = 4'b1111 and spike_count = 4 every step.
6. Reset and handshake edge cases:
   - Assert reset during UPDATE at idx=2: no out_valid; all potentials return to 0; the next step behaves like step 1 of test 2.
   - Pulse in_valid during UPDATE: the pulse is ignored.

Source files
------------

// File: rtl/lif_neuron_array_if.sv
// lif_neuron_array_if: timestep request/response bundle for the LIF neuron array
interface lif_neuron_array_if #(
   parameter int N_NEURONS       = 8,
   parameter int POTENTIAL_WIDTH = 16,
   parameter int FRACTION_BITS   = 8,
   parameter int REFRAC_WIDTH    = 4
);
   localparam int CW = $clog2(N_NEURONS + 1);
   logic                       in_valid;
   logic                       in_ready;
   logic [N_NEURONS-1:0]       in_spikes;
   logic [FRACTION_BITS-1:0]   lambda_val_scaled;
   logic [POTENTIAL_WIDTH-1:0] weight_scaled;
   logic [POTENTIAL_WIDTH-1:0] theta_val_scaled;
   logic [POTENTIAL_WIDTH-1:0] reset_val_scaled;
   logic [REFRAC_WIDTH-1:0]    refrac_steps;
   logic                       out_valid;
   logic [N_NEURONS-1:0]       out_spikes;
   logic [CW-1:0]              spike_count;
   modport master (
      output in_valid, in_spikes, lambda_val_scaled, weight_scaled,
             theta_val_scaled, reset_val_scaled, refrac_steps,
      input  in_ready, out_valid, out_spikes, spike_count
   );
   modport slave (
      input  in_valid, in_spikes, lambda_val_scaled, weight_scaled,
             theta_val_scaled, reset_val_scaled, refrac_steps,
      output in_ready, out_valid, out_spikes, spike_count
   );
endinterface

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: time-multiplexed LIF neurons sharing one leak/integrate/fire datapath
module lif_neuron_array #(
   parameter int N_NEURONS       = 8,
   parameter int POTENTIAL_WIDTH = 16,
   parameter int FRACTION_BITS   = 8,
   parameter int REFRAC_WIDTH    = 4
) (
   input logic clk,
   input logic reset,
   lif_neuron_array_if.slave bus
);
   localparam int PW = POTENTIAL_WIDTH;
   localparam int FB = FRACTION_BITS;
   localparam int RW = REFRAC_WIDTH;
   localparam int IW = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1;
   localparam int CW = $clog2(N_NEURONS + 1);
   typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;
   state_t state, state_nx;
   logic [IW-1:0]        idx;
   logic [N_NEURONS-1:0] spk_in, spk_acc, spk_nx, spk_out;
   logic [FB-1:0]        lam_q;
   logic [PW-1:0]        w_q, th_q, rv_q;
   logic [RW-1:0]        rf_q;
   logic [PW-1:0]        pot [N_NEURONS];
   logic [RW-1:0]        rcnt [N_NEURONS];
   logic [PW+FB-1:0]     prod;
   logic [PW-1:0]        leak, sat;
   logic [PW:0]          sum;
   logic [CW-1:0]        cnt_nx, cnt_q;
   logic                 last, refr, fire;
   assign last = idx == IW'(N_NEURONS - 1);
   assign prod = (PW+FB)'(pot[idx]) * (PW+FB)'(lam_q);
   assign leak = PW'(prod >> FB);
   assign sum  = {1'b0, leak} + {1'b0, spk_in[idx] ? w_q : '0};
   assign sat  = sum[PW] ? '1 : sum[PW-1:0];
   assign refr = rcnt[idx] != '0;
   assign fire = !refr && sat >= th_q;
   assign spk_nx = spk_acc | (N_NEURONS'(fire) << idx);
   assign bus.in_ready    = state == IDLE;
   assign bus.out_valid   = state == DONE;
   assign bus.out_spikes  = spk_out;
   assign bus.spike_count = cnt_q;
   always_comb begin
      cnt_nx = '0;
      for (int i = 0; i < N_NEURONS; i++) cnt_nx += CW'(spk_nx[i]);
   end
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE   ? (bus.in_valid ? UPDATE : IDLE) :
                 state == UPDATE ? (last ? DONE : UPDATE) : IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   // Step parameters are latched at acceptance so the sweep sees a stable configuration.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx     <= '0;
         spk_in  <= '0;
         spk_acc <= '0;
         spk_out <= '0;
         cnt_q   <= '0;
         lam_q   <= '0;
         w_q     <= '0;
         th_q    <= '0;
         rv_q    <= '0;
         rf_q    <= '0;
         for (int i = 0; i < N_NEURONS; i++) begin
            pot[i]  <= '0;
            rcnt[i] <= '0;
         end
      end else if (state == IDLE) begin
         if (bus.in_valid) begin
            idx     <= '0;
            spk_acc <= '0;
            spk_in  <= bus.in_spikes;
            lam_q   <= bus.lambda_val_scaled;
            w_q     <= bus.weight_scaled;
            th_q    <= bus.theta_val_scaled;
            rv_q    <= bus.reset_val_scaled;
            rf_q    <= bus.refrac_steps;
         end
      end else if (state == UPDATE) begin
         idx     <= idx + IW'(1);
         spk_acc <= spk_nx;
         if (refr) rcnt[idx] <= rcnt[idx] - RW'(1);
         else if (fire) begin
            pot[idx]  <= rv_q;
            rcnt[idx] <= rf_q;
         end else pot[idx] <= sat;
         if (last) begin
            spk_out <= spk_nx;
            cnt_q   <= cnt_nx;
         end
      end
   end
endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: directed scoreboard bench for lif_neuron_array
module tb_lif_neuron_array;
   localparam int N  = 4;
   localparam int PW = 16;
   localparam int FB = 8;
   localparam int RW = 4;
   localparam int CW = $clog2(N + 1);
   typedef struct {
      logic [N-1:0]  spk;
      logic [CW-1:0] cnt;
      int            acc_cyc;
      string         tag;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t sb[$];
   lif_neuron_array_if #(.N_NEURONS(N), .POTENTIAL_WIDTH(PW), .FRACTION_BITS(FB), .REFRAC_WIDTH(RW)) bus ();
   lif_neuron_array #(.N_NEURONS(N), .POTENTIAL_WIDTH(PW), .FRACTION_BITS(FB), .REFRAC_WIDTH(RW)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cfg(input int lam, input int w, input int th, input int rv, input int rs);
      bus.lambda_val_scaled = FB'(lam);
      bus.weight_scaled     = PW'(w);
      bus.theta_val_scaled  = PW'(th);
      bus.reset_val_scaled  = PW'(rv);
      bus.refrac_steps      = RW'(rs);
   endtask
   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk({tag, " rst in_ready"}, bus.in_ready, 1);
      chk({tag, " rst out_valid"}, bus.out_valid, 0);
      chk({tag, " rst spike_count"}, bus.spike_count, 0);
      chk({tag, " rst out_spikes"}, bus.out_spikes, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic step(input string tag, input logic [N-1:0] si, input logic [N-1:0] exp_spk, input bit pulse);
      exp_t e;
      int t;
      @(negedge clk);
      bus.in_spikes = si;
      bus.in_valid  = 1'b1;
      chk({tag, " in_ready"}, bus.in_ready, 1);
      e.spk = exp_spk;
      e.cnt = CW'($countones(exp_spk));
      e.acc_cyc = cyc;
      e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.in_spikes = ~si;
      if (pulse) begin
         @(negedge clk);
         chk({tag, " busy in_ready"}, bus.in_ready, 0);
         bus.in_valid  = 1'b1;
         bus.in_spikes = '1;
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      t = 0;
      while (!bus.out_valid && t < 3 * N) begin
         @(negedge clk);
         t++;
      end
      e = sb.pop_front();
      chk({e.tag, " out_valid"}, bus.out_valid, 1);
      chk({e.tag, " latency"}, 32'(cyc - e.acc_cyc), N + 1);
      chk({e.tag, " out_spikes"}, bus.out_spikes, e.spk);
      chk({e.tag, " spike_count"}, bus.spike_count, e.cnt);
      @(negedge clk);
      chk({e.tag, " pulse end"}, bus.out_valid, 0);
      chk({e.tag, " back idle"}, bus.in_ready, 1);
      chk({e.tag, " out hold"}, bus.out_spikes, e.spk);
   endtask
   initial begin
      logic seen;
      bus.in_valid  = 1'b0;
      bus.in_spikes = '0;
      cfg(128, 256, 384, 0, 0);
      do_reset("t1");
      repeat (3) @(negedge clk);
      chk("t1 idle out_valid", bus.out_valid, 0);
      chk("t1 idle in_ready", bus.in_ready, 1);
      // integrate and fire, period 2
      step("t2 s1", 4'b0001, 4'b0000, 0);
      step("t2 s2", 4'b0001, 4'b0001, 0);
      step("t2 s3", 4'b0001, 4'b0000, 0);
      step("t2 s4", 4'b0001, 4'b0001, 0);
      step("t2 s5", 4'b0001, 4'b0000, 0);
      step("t2 s6", 4'b0001, 4'b0001, 0);
      // refractory period of two steps
      do_reset("t3");
      cfg(128, 256, 384, 0, 2);
      step("t3 s1", 4'b0001, 4'b0000, 0);
      step("t3 s2", 4'b0001, 4'b0001, 0);
      step("t3 s3", 4'b0001, 4'b0000, 0);
      step("t3 s4", 4'b0001, 4'b0000, 0);
      step("t3 s5", 4'b0001, 4'b0000, 0);
      step("t3 s6", 4'b0001, 4'b0001, 0);
      // saturation: 0xEF10 + 0xF000 clamps to 0xFFFF
      do_reset("t4");
      cfg(255, 16'hF000, 16'hFFFF, 0, 0);
      step("t4 s1", 4'b0001, 4'b0000, 0);
      step("t4 s2", 4'b0001, 4'b0001, 0);
      step("t4 s3", 4'b0001, 4'b0000, 0);
      // all channels fire together
      do_reset("t5");
      cfg(128, 256, 256, 0, 0);
      step("t5 s1", 4'b1111, 4'b1111, 0);
      step("t5 s2", 4'b1111, 4'b1111, 0);
      step("t5 s3", 4'b0101, 4'b0101, 0);
      // theta = 0 fires every non-refractory neuron, input or not
      cfg(128, 256, 0, 0, 0);
      step("th0 s1", 4'b0000, 4'b1111, 0);
      step("th0 s2", 4'b0000, 4'b1111, 0);
      // lambda = 0 clears potential before integrating
      do_reset("lam0");
      cfg(0, 200, 300, 0, 0);
      step("lam0 s1", 4'b0001, 4'b0000, 0);
      step("lam0 s2", 4'b0001, 4'b0000, 0);
      step("lam0 s3", 4'b0001, 4'b0000, 0);
      // reset_val above theta fires on the following step
      do_reset("rv");
      cfg(128, 256, 384, 1000, 0);
      step("rv s1", 4'b0001, 4'b0000, 0);
      step("rv s2", 4'b0001, 4'b0001, 0);
      step("rv s3", 4'b0000, 4'b0001, 0);
      // reset mid-sweep discards the step and clears potentials
      do_reset("t6");
      cfg(128, 256, 384, 0, 0);
      step("t6 s1", 4'b1111, 4'b0000, 0);
      @(negedge clk);
      bus.in_spikes = 4'b1111;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("t6 midrst out_valid", bus.out_valid, 0);
      chk("t6 midrst in_ready", bus.in_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (N + 3) begin
         @(negedge clk);
         seen = seen | bus.out_valid;
      end
      chk("t6 no out_valid", seen, 0);
      step("t6 s1 again", 4'b1111, 4'b0000, 0);
      step("t6 s2 again", 4'b1111, 4'b1111, 0);
      // in_valid pulse while busy is ignored
      do_reset("t6b");
      step("t6b s1", 4'b0001, 4'b0000, 1);
      seen = 1'b0;
      repeat (N + 3) begin
         @(negedge clk);
         seen = seen | bus.out_valid;
      end
      chk("t6b no extra step", seen, 0);
      step("t6b s2", 4'b0001, 4'b0001, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
